// File: rtl/ma_stage.sv
// Memory-access stage: passes non-memory instructions straight to RW and runs
// loads/stores over a req/gnt/rvalid data port with timeout and misalignment aborts.
module ma_stage #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic        Ex_Valid,
    output logic        Ex_Ready,
    input  logic [31:0] Ex_Pc,
    input  logic [31:0] Ex_AluResult,
    input  logic [31:0] Ex_Op2,
    input  logic [31:0] Ex_Instr,
    input  logic        Ex_IsLd,
    input  logic        Ex_IsSt,
    input  logic        Ex_IsWb,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    input  logic        Mem_Gnt,
    input  logic        Mem_RValid,
    input  logic [31:0] Mem_RData,
    output logic        Ma_Valid,
    input  logic        Ma_Ready,
    output logic [31:0] Ma_Pc,
    output logic [31:0] Ma_AluResult,
    output logic [31:0] Ma_Instr,
    output logic [31:0] Ma_LdResult,
    output logic        Ma_IsLd,
    output logic        Ma_IsWb,
    output logic        Ma_Err
);
    localparam int             CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, WAIT_RD = 2'b10, DONE = 2'b11} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] instr;
        logic        is_ld;
        logic        is_wb;
    } pay_t;

    state_t        state;
    pay_t          pay;
    logic [CW-1:0] tmo_cnt;
    logic          accept, is_mem, misal, tmo_last;
    logic          fin, fin_err;
    logic [31:0]   fin_data;

    assign Ex_Ready = Rst && (state == IDLE) && (!Ma_Valid || Ma_Ready);
    assign accept   = Ex_Valid && Ex_Ready && Start;
    assign is_mem   = Ex_IsLd || Ex_IsSt;
    assign misal    = is_mem && (Ex_AluResult[1:0] != 2'b00);
    assign tmo_last = (tmo_cnt == TMO_LAST);

    // Completion of an in-flight memory op; result lands on Ma_* as DONE is entered.
    always_comb begin
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_data = '0;
        case (state)
            REQ: begin
                if (Mem_Gnt) begin
                    fin = Mem_We;
                end else if (tmo_last) begin
                    fin      = 1'b1;
                    fin_err  = 1'b1;
                    fin_data = pay.is_ld ? ERR_DATA : '0;
                end
            end
            WAIT_RD: begin
                if (Mem_RValid) begin
                    fin      = 1'b1;
                    fin_data = Mem_RData;
                end else if (tmo_last) begin
                    fin      = 1'b1;
                    fin_err  = 1'b1;
                    fin_data = ERR_DATA;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            pay          <= '0;
            Mem_Req      <= 1'b0;
            Mem_We       <= 1'b0;
            Mem_Addr     <= '0;
            Mem_WData    <= '0;
            Ma_Valid     <= 1'b0;
            Ma_Pc        <= '0;
            Ma_AluResult <= '0;
            Ma_Instr     <= '0;
            Ma_LdResult  <= '0;
            Ma_IsLd      <= 1'b0;
            Ma_IsWb      <= 1'b0;
            Ma_Err       <= 1'b0;
        end else begin
            if (Ma_Valid && Ma_Ready)
                Ma_Valid <= 1'b0;
            if (fin) begin
                Ma_Valid     <= 1'b1;
                Ma_Pc        <= pay.pc;
                Ma_AluResult <= pay.alu;
                Ma_Instr     <= pay.instr;
                Ma_IsLd      <= pay.is_ld;
                Ma_IsWb      <= pay.is_wb;
                Ma_LdResult  <= fin_data;
                Ma_Err       <= fin_err;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mem && !misal) begin
                            state     <= REQ;
                            tmo_cnt   <= '0;
                            Mem_Req   <= 1'b1;
                            Mem_We    <= Ex_IsSt;
                            Mem_Addr  <= Ex_AluResult;
                            Mem_WData <= Ex_Op2;
                            pay       <= '{Ex_Pc, Ex_AluResult, Ex_Instr, Ex_IsLd, Ex_IsWb};
                        end else begin
                            // Non-memory and misaligned ops retire in one cycle.
                            Ma_Valid     <= 1'b1;
                            Ma_Pc        <= Ex_Pc;
                            Ma_AluResult <= Ex_AluResult;
                            Ma_Instr     <= Ex_Instr;
                            Ma_IsLd      <= Ex_IsLd;
                            Ma_IsWb      <= Ex_IsWb;
                            Ma_LdResult  <= (misal && Ex_IsLd) ? ERR_DATA : '0;
                            Ma_Err       <= misal;
                        end
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (Mem_Gnt) begin
                        Mem_Req <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= Mem_We ? DONE : WAIT_RD;
                    end else if (tmo_last) begin
                        Mem_Req <= 1'b0;
                        state   <= DONE;
                    end
                end
                WAIT_RD: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (Mem_RValid || tmo_last)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ma_stage.sv
// Directed bench for ma_stage: single-cycle vector table plus hand-written
// load/store, timeout, stall, Start and reset sequences.
module tb_ma_stage;
    logic        Clk = 1'b0;
    logic        Rst, Start, Ex_Valid, Ex_Ready;
    logic [31:0] Ex_Pc, Ex_AluResult, Ex_Op2, Ex_Instr;
    logic        Ex_IsLd, Ex_IsSt, Ex_IsWb;
    logic        Mem_Req, Mem_We, Mem_Gnt, Mem_RValid;
    logic [31:0] Mem_Addr, Mem_WData, Mem_RData;
    logic        Ma_Valid, Ma_Ready, Ma_IsLd, Ma_IsWb, Ma_Err;
    logic [31:0] Ma_Pc, Ma_AluResult, Ma_Instr, Ma_LdResult;

    int total = 0;
    int bad   = 0;

    ma_stage dut (
        .Clk(Clk), .Rst(Rst), .Start(Start),
        .Ex_Valid(Ex_Valid), .Ex_Ready(Ex_Ready), .Ex_Pc(Ex_Pc), .Ex_AluResult(Ex_AluResult),
        .Ex_Op2(Ex_Op2), .Ex_Instr(Ex_Instr), .Ex_IsLd(Ex_IsLd), .Ex_IsSt(Ex_IsSt), .Ex_IsWb(Ex_IsWb),
        .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
        .Mem_Gnt(Mem_Gnt), .Mem_RValid(Mem_RValid), .Mem_RData(Mem_RData),
        .Ma_Valid(Ma_Valid), .Ma_Ready(Ma_Ready), .Ma_Pc(Ma_Pc), .Ma_AluResult(Ma_AluResult),
        .Ma_Instr(Ma_Instr), .Ma_LdResult(Ma_LdResult), .Ma_IsLd(Ma_IsLd), .Ma_IsWb(Ma_IsWb),
        .Ma_Err(Ma_Err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic drive(input logic [31:0] pc, alu, op2, instr, input logic ld, st, wb);
        Ex_Pc = pc; Ex_AluResult = alu; Ex_Op2 = op2; Ex_Instr = instr;
        Ex_IsLd = ld; Ex_IsSt = st; Ex_IsWb = wb; Ex_Valid = 1'b1;
    endtask

    typedef struct {
        logic [31:0] pc, alu, op2, instr;
        logic        ld, st, wb;
        logic [31:0] ldres;
        logic        err;
    } vec_t;

    vec_t vt[5];
    int   req_n, vld_n, rdy_n;

    initial begin
        vt[0] = '{32'h1000, 32'h0000_0010, 32'h0, 32'h0000_0033, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0};
        vt[1] = '{32'h1004, 32'h0000_0102, 32'h0, 32'h0000_0003, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1};
        vt[2] = '{32'h1008, 32'h0000_0203, 32'h7, 32'h0000_0023, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1};
        vt[3] = '{32'h100C, 32'hFFFF_FFFF, 32'h0, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0};
        vt[4] = '{32'h1010, 32'h0000_0101, 32'h0, 32'h0000_0003, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1};

        Rst = 1'b0; Start = 1'b1; Ma_Ready = 1'b1;
        Mem_Gnt = 1'b0; Mem_RValid = 1'b0; Mem_RData = '0;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        Ex_Valid = 1'b0;
        tick(); tick();
        chk("rst_ma_valid", Ma_Valid, 0);
        chk("rst_mem_req", Mem_Req, 0);
        chk("rst_ex_ready", Ex_Ready, 0);
        chk("rst_ldres", Ma_LdResult, 0);
        chk("rst_err", Ma_Err, 0);
        Rst = 1'b1;
        tick();
        chk("post_rst_ex_ready", Ex_Ready, 1);

        // single-cycle ops: plain ALU and misaligned ld/st
        for (int i = 0; i < 5; i++) begin
            drive(vt[i].pc, vt[i].alu, vt[i].op2, vt[i].instr, vt[i].ld, vt[i].st, vt[i].wb);
            tick();
            Ex_Valid = 1'b0;
            chk($sformatf("v%0d_valid", i), Ma_Valid, 1);
            chk($sformatf("v%0d_pc", i), Ma_Pc, vt[i].pc);
            chk($sformatf("v%0d_alu", i), Ma_AluResult, vt[i].alu);
            chk($sformatf("v%0d_instr", i), Ma_Instr, vt[i].instr);
            chk($sformatf("v%0d_ldres", i), Ma_LdResult, vt[i].ldres);
            chk($sformatf("v%0d_err", i), Ma_Err, vt[i].err);
            chk($sformatf("v%0d_isld", i), Ma_IsLd, vt[i].ld);
            chk($sformatf("v%0d_iswb", i), Ma_IsWb, vt[i].wb);
            chk($sformatf("v%0d_nomemreq", i), Mem_Req, 0);
        end
        tick();
        chk("idle_valid_drop", Ma_Valid, 0);

        // aligned load: Gnt on the 3rd Req cycle, RValid 3 cycles later
        drive(32'h2000, 32'h100, 32'h0, 32'h0000_2003, 1'b1, 1'b0, 1'b1);
        req_n = 0; vld_n = 0; rdy_n = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            Ex_Valid = 1'b0;
            req_n += int'(Mem_Req);
            vld_n += int'(Ma_Valid);
            rdy_n += int'(Ex_Ready);
            if (c == 1) begin
                chk("ld_addr", Mem_Addr, 32'h100);
                chk("ld_we", Mem_We, 0);
            end
            Mem_Gnt    = (c == 3);
            Mem_RValid = (c == 6);
            Mem_RData  = (c == 6) ? 32'hCAFE_F00D : 32'h0;
        end
        chk("ld_req_cycles", req_n, 3);
        chk("ld_ex_ready_seen", rdy_n, 0);
        chk("ld_valid_cycles", vld_n, 1);
        chk("ld_valid", Ma_Valid, 1);
        chk("ld_result", Ma_LdResult, 32'hCAFE_F00D);
        chk("ld_err", Ma_Err, 0);
        chk("ld_pc", Ma_Pc, 32'h2000);
        Mem_RValid = 1'b0;
        tick();

        // store granted in its first Req cycle
        drive(32'h3000, 32'h204, 32'h55, 32'h0000_0023, 1'b0, 1'b1, 1'b0);
        tick();
        Ex_Valid = 1'b0;
        chk("st_req", Mem_Req, 1);
        chk("st_we", Mem_We, 1);
        chk("st_wdata", Mem_WData, 32'h55);
        chk("st_addr", Mem_Addr, 32'h204);
        chk("st_not_yet_valid", Ma_Valid, 0);
        Mem_Gnt = 1'b1;
        tick();
        Mem_Gnt = 1'b0;
        chk("st_req_drop", Mem_Req, 0);
        chk("st_valid", Ma_Valid, 1);
        chk("st_ldres", Ma_LdResult, 0);
        chk("st_err", Ma_Err, 0);
        tick();

        // load that is never granted: aborts after TIMEOUT Req cycles
        drive(32'h4000, 32'h300, 32'h0, 32'h0000_0003, 1'b1, 1'b0, 1'b1);
        req_n = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            Ex_Valid = 1'b0;
            if (Ma_Valid) break;
            req_n += int'(Mem_Req);
        end
        chk("tmo_req_cycles", req_n, 64);
        chk("tmo_valid", Ma_Valid, 1);
        chk("tmo_err", Ma_Err, 1);
        chk("tmo_ldres", Ma_LdResult, 32'hDEAD_BEEF);
        chk("tmo_req_drop", Mem_Req, 0);
        tick();
        drive(32'h4004, 32'h44, 32'h0, 32'h0000_0033, 1'b0, 1'b0, 1'b1);
        tick();
        Ex_Valid = 1'b0;
        chk("tmo_next_valid", Ma_Valid, 1);
        chk("tmo_next_alu", Ma_AluResult, 32'h44);
        chk("tmo_next_err", Ma_Err, 0);
        tick();

        // RW stall: outputs held, then back-to-back reload on release
        Ma_Ready = 1'b0;
        drive(32'h5000, 32'h77, 32'h0, 32'h0000_0033, 1'b0, 1'b0, 1'b1);
        tick();
        drive(32'h5004, 32'h88, 32'h0, 32'h0000_0033, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold%0d_valid", c), Ma_Valid, 1);
            chk($sformatf("hold%0d_alu", c), Ma_AluResult, 32'h77);
            chk($sformatf("hold%0d_ex_ready", c), Ex_Ready, 0);
            tick();
        end
        Ma_Ready = 1'b1;
        tick();
        Ex_Valid = 1'b0;
        chk("b2b_valid", Ma_Valid, 1);
        chk("b2b_alu", Ma_AluResult, 32'h88);
        chk("b2b_pc", Ma_Pc, 32'h5004);
        tick();
        chk("b2b_drop", Ma_Valid, 0);

        // Start low mid-load: op completes, new acceptance blocked
        drive(32'h6000, 32'h500, 32'h0, 32'h0000_0003, 1'b1, 1'b0, 1'b1);
        tick();
        Ex_Valid = 1'b0;
        Start = 1'b0;
        Mem_Gnt = 1'b1;
        tick();
        Mem_Gnt = 1'b0;
        Mem_RValid = 1'b1; Mem_RData = 32'h1234_5678;
        tick();
        Mem_RValid = 1'b0;
        chk("start_ld_valid", Ma_Valid, 1);
        chk("start_ld_result", Ma_LdResult, 32'h1234_5678);
        drive(32'h6004, 32'h99, 32'h0, 32'h0000_0033, 1'b0, 1'b0, 1'b1);
        tick(); tick(); tick();
        chk("start_blocked_valid", Ma_Valid, 0);
        Start = 1'b1;
        tick();
        Ex_Valid = 1'b0;
        chk("start_resume_alu", Ma_AluResult, 32'h99);

        // reset while waiting for read data; late RValid must be ignored
        drive(32'h7000, 32'h400, 32'h0, 32'h0000_0003, 1'b1, 1'b0, 1'b1);
        tick();
        Ex_Valid = 1'b0;
        Mem_Gnt = 1'b1;
        tick();
        Mem_Gnt = 1'b0;
        Rst = 1'b0;
        tick();
        chk("rrd_mem_req", Mem_Req, 0);
        chk("rrd_mem_addr", Mem_Addr, 0);
        chk("rrd_ma_valid", Ma_Valid, 0);
        chk("rrd_ma_pc", Ma_Pc, 0);
        chk("rrd_ma_alu", Ma_AluResult, 0);
        chk("rrd_ex_ready", Ex_Ready, 0);
        Rst = 1'b1;
        Mem_RValid = 1'b1; Mem_RData = 32'h9999_9999;
        tick();
        Mem_RValid = 1'b0;
        chk("rrd_late_valid", Ma_Valid, 0);
        chk("rrd_late_ldres", Ma_LdResult, 0);
        chk("rrd_ex_ready_idle", Ex_Ready, 1);
        tick();
        chk("rrd_late_valid2", Ma_Valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
